ula_mul_seq: RTL and testbench
==============================

Name: ula_mul_seq

Overview:
Multi-cycle multiply sequencer that drives the shared ULA (add/shift ALU) to compute the low WIDTH bits of a x b. It uses the shift-add algorithm with early termination. It sits beside the datapath and requests the ULA through a request/grant pair, so the main datapath keeps priority. It accepts operands with a valid/ready handshake and returns the product with a valid/ready handshake. It serves as the MUL execution path for the core.

Parameters:
WIDTH, 32, operand/result/ULA width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand pair valid
start_ready  output  1  sequencer can accept operands (high only in IDLE)
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
result_valid  output  1  product available
result_ready  input  1  consumer takes product
result  output  WIDTH  product mod 2^WIDTH
result_zero  output  1  result == 0 (valid only with result_valid)
ula_req  output  1  sequencer needs the ULA this cycle
ula_gnt  input  1  ULA granted to sequencer this cycle
ula_a  output  WIDTH  drives ULA SrcA
ula_b  output  WIDTH  drives ULA SrcB
ula_ctrl  output  3  drives ULAControl (000 add, 110 shift-left)
ula_result  input  WIDTH  ULAResult, combinational from ula_a/ula_b/ula_ctrl

Behaviour:
- Registers: acc, mcand, mplier (WIDTH each); state in {IDLE, ADD, SHL, DONE}.
- Reset (async, rst_n=0): state=IDLE, acc/mcand/mplier=0.
- Outputs during reset: start_ready=1, result_valid=0, ula_req=0, ula_a/ula_b=0, ula_ctrl=000, result=0, result_zero=1.
- Reset mid-operation aborts the operation with no output.
- start_ready = (state==IDLE).
- result = acc; result_zero = ~|acc.
- ula_req = (state==ADD or SHL).
- In IDLE and DONE, ula_a/ula_b/ula_ctrl are 0/0/000.
- IDLE, start_valid=1 (accept edge):
  - Load mcand<=op_a, mplier<=op_b, acc<=0.
  - Next state: DONE if op_b==0; ADD if op_b[0]=1; otherwise SHL.
- ADD:
  - Drive ula_a=acc, ula_b=mcand, ula_ctrl=000.
  - If ula_gnt=1: acc<=ula_result, next SHL.
  - If ula_gnt=0: hold all registers and state.
- SHL:
  - Drive ula_a=mcand, ula_b=1, ula_ctrl=110.
  - If ula_gnt=1: mcand<=ula_result and mplier<=mplier>>1 (logical).
  - Next state, with m'=mplier>>1: DONE if m'==0; ADD if m'[0]=1; otherwise SHL.
  - If ula_gnt=0: hold.
- DONE:
  - result_valid=1; result is held stable until result_ready=1.
  - On result_valid & result_ready: state<=IDLE; acc is not cleared.
  - A new operation can be accepted one cycle after the handshake, never in the same cycle.
- start_valid is ignored outside IDLE; op_a/op_b are sampled only at the accept edge.
- Arithmetic is mod 2^WIDTH, with no overflow flag. Low bits equal the two's-complement signed product, so the block serves MUL for both signed and unsigned operands.
- Latency with continuous grant: result_valid rises popcount(b) + bitlen(b) + 1 cycles after the accept cycle.
  - bitlen(b) = index of the highest set bit + 1; bitlen(0)=0.
  - Each cycle with ula_req=1 and ula_gnt=0 adds exactly 1 cycle.
- ula_req and the ULA drive signals depend only on state and registers, never on ula_gnt (no combinational loop).

Test Plan:
1. a=3, b=5, gnt=1 -> ula_ctrl sequence 000,110,110,000,110; result_valid 6 cycles after accept; result=15, result_zero=0.
2. a=0xFFFFFFFF, b=0 -> ula_req never asserted; result_valid 1 cycle after accept; result=0, result_zero=1.
3. a=0xFFFFFFFF, b=0xFFFFFFFF, gnt=1 -> result=0x00000001 after 65 cycles. Also a=0xFFFFFFFE (-2), b=3 -> result=0xFFFFFFFA.
4. a=7, b=3, gnt forced 0 for 4 cycles while in first ADD -> acc/state held, ula_req stays 1; result=21 after 5+4=9 cycles.
5. result_ready=0 for 3 cycles in DONE, with start_valid=1 and new operands -> result/result_valid held, start_ready=0, operands ignored. Then ready=1 -> IDLE next cycle, start_ready=1.
6. rst_n pulsed low mid-SHL -> outputs return to reset values immediately. After release, a=12, b=10 -> result=120, latency 2+4+1=7.

Source files
------------

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: shift-add multiply sequencer that borrows the shared ULA
// (add / shift-left ALU) through a request/grant pair and returns the low
// WIDTH bits of op_a * op_b. Because only the low bits are kept, the result
// is the same for signed and unsigned operands.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_valid/start_ready    operand handshake (ready only in IDLE)
//   op_a, op_b                 multiplicand / multiplier, sampled at accept
//   result_valid/result_ready  product handshake
//   result, result_zero        product (mod 2^WIDTH) and its zero flag
//   ula_req/ula_gnt            ULA arbitration (datapath keeps priority)
//   ula_a, ula_b, ula_ctrl     ULA operand / control drive
//   ula_result                 combinational ULA output
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// ADD   | acc <= acc + mcand through the ULA (multiplier bit 0 is set)
// SHL   | mcand <= mcand << 1 through the ULA, multiplier shifted right
// DONE  | product on result, waiting for result_ready

module ula_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             ula_req,
  input  logic             ula_gnt,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_ctrl,
  input  logic [WIDTH-1:0] ula_result
);

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SHL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SHL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_sh;

  assign mplier_sh   = mplier >> 1;
  assign result      = acc;
  assign result_zero = ~|acc;

  // Nothing here looks at ula_gnt except the next-state choice, so the ULA
  // drive and the request never form a loop through the arbiter.
  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    ula_req      = 1'b0;
    ula_a        = '0;
    ula_b        = '0;
    ula_ctrl     = CTRL_ADD;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          if (op_b == '0)    state_nxt = DONE;
          else if (op_b[0])  state_nxt = ADD;
          else               state_nxt = SHL;
        end
      end
      ADD: begin
        ula_req  = 1'b1;
        ula_a    = acc;
        ula_b    = mcand;
        ula_ctrl = CTRL_ADD;
        if (ula_gnt) state_nxt = SHL;
      end
      SHL: begin
        ula_req  = 1'b1;
        ula_a    = mcand;
        ula_b    = WIDTH'(1);
        ula_ctrl = CTRL_SHL;
        // Early exit as soon as no multiplier bits remain.
        if (ula_gnt) begin
          if (mplier_sh == '0)    state_nxt = DONE;
          else if (mplier_sh[0])  state_nxt = ADD;
          else                    state_nxt = SHL;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
          end
        end
        ADD: begin
          if (ula_gnt) acc <= ula_result;
        end
        SHL: begin
          if (ula_gnt) begin
            mcand  <= ula_result;
            mplier <= mplier_sh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mul_seq.sv
// Directed bench for ula_mul_seq: a table of operand pairs with hand-computed
// products and latencies, plus hand-written sequences for grant stalls,
// result back-pressure and reset mid-operation.

module tb_ula_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result;
  logic         result_zero;
  logic         ula_req;
  logic         ula_gnt = 1'b1;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic [2:0]   ula_ctrl;
  logic [W-1:0] ula_result;

  always #5 clk = ~clk;

  // Reference ULA: add or shift-left.
  assign ula_result = (ula_ctrl == 3'b110) ? (ula_a << ula_b) : (ula_a + ula_b);

  ula_mul_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .result_zero  (result_zero),
    .ula_req      (ula_req),
    .ula_gnt      (ula_gnt),
    .ula_a        (ula_a),
    .ula_b        (ula_b),
    .ula_ctrl     (ula_ctrl),
    .ula_result   (ula_result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    int           lat;
  } vec_t;

  vec_t       vecs[10];
  logic [2:0] ctrl_q[$];

  task automatic check_reset_outputs(input string tag);
    check({tag, " start_ready"},  W'(start_ready),  W'(1));
    check({tag, " result_valid"}, W'(result_valid), W'(0));
    check({tag, " ula_req"},      W'(ula_req),      W'(0));
    check({tag, " ula_a"},        ula_a,            W'(0));
    check({tag, " ula_b"},        ula_b,            W'(0));
    check({tag, " ula_ctrl"},     W'(ula_ctrl),     W'(0));
    check({tag, " result"},       result,           W'(0));
    check({tag, " result_zero"},  W'(result_zero),  W'(1));
  endtask

  // Accepts one operand pair and waits for result_valid; leaves the DUT in
  // DONE with result_ready low. Grant is dropped on cycles
  // [stall_from, stall_from+stall_len) counted from the accept cycle (= 0).
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_zero, input int exp_lat,
                        input int stall_from, input int stall_len);
    int           cyc;
    logic [W-1:0] held_res;
    logic [2:0]   held_ctrl;
    held_res  = '0;
    held_ctrl = '0;
    ctrl_q.delete();
    check({tag, " start_ready at accept"}, W'(start_ready), W'(1));
    op_a        = a;
    op_b        = b;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h5555_5555;
    cyc = 1;
    while (!result_valid && cyc < 200) begin
      ula_gnt = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (cyc == stall_from) begin
        held_res  = result;
        held_ctrl = ula_ctrl;
      end
      if (!ula_gnt) begin
        check({tag, " stall ula_req"},  W'(ula_req),  W'(1));
        check({tag, " stall acc"},      result,       held_res);
        check({tag, " stall ula_ctrl"}, W'(ula_ctrl), W'(held_ctrl));
      end
      if (ula_req && ula_gnt) ctrl_q.push_back(ula_ctrl);
      @(posedge clk); #1;
      cyc++;
    end
    ula_gnt = 1'b1;
    check({tag, " latency"},     W'(cyc),           W'(exp_lat));
    check({tag, " result"},      result,            exp_res);
    check({tag, " result_zero"}, W'(result_zero),   W'(exp_zero));
    check({tag, " ula ops"},     W'(ctrl_q.size()), W'(exp_lat - 1 - stall_len));
  endtask

  task automatic take_result(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({tag, " back to IDLE"}, W'(start_ready),  W'(1));
    check({tag, " valid drops"},  W'(result_valid), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]   exp_ctrl[5];
    logic [W-1:0] hold_res;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          res: 32'd15,         zero: 1'b0, lat: 6};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd0,          res: 32'd0,          zero: 1'b1, lat: 1};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  res: 32'd1,          zero: 1'b0, lat: 65};
    vecs[3] = '{a: 32'hFFFF_FFFE,  b: 32'd3,          res: 32'hFFFF_FFFA,  zero: 1'b0, lat: 5};
    vecs[4] = '{a: 32'd12,         b: 32'd10,         res: 32'd120,        zero: 1'b0, lat: 7};
    vecs[5] = '{a: 32'd0,          b: 32'd7,          res: 32'd0,          zero: 1'b1, lat: 7};
    vecs[6] = '{a: 32'd1,          b: 32'h8000_0000,  res: 32'h8000_0000,  zero: 1'b0, lat: 34};
    vecs[7] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  res: 32'd0,          zero: 1'b1, lat: 19};
    vecs[8] = '{a: 32'd5,          b: 32'd1,          res: 32'd5,          zero: 1'b0, lat: 3};
    vecs[9] = '{a: 32'h1234_5678,  b: 32'd2,          res: 32'h2468_ACF0,  zero: 1'b0, lat: 4};

    // Reset values, with start_valid asserted during reset.
    start_valid = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    #12;
    check_reset_outputs("in reset");
    start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset start_ready", W'(start_ready), W'(1));

    // 3 x 5: exact ULA control sequence.
    run_op("3x5", 32'd3, 32'd5, 32'd15, 1'b0, 6, 0, 0);
    exp_ctrl = '{3'b000, 3'b110, 3'b110, 3'b000, 3'b110};
    for (int i = 0; i < 5; i++) begin
      if (i < ctrl_q.size()) check($sformatf("3x5 ctrl[%0d]", i), W'(ctrl_q[i]), W'(exp_ctrl[i]));
      else check($sformatf("3x5 ctrl[%0d] missing", i), W'(ctrl_q.size()), W'(5));
    end
    take_result("3x5");

    // Table of products.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero,
             vecs[i].lat, 0, 0);
      take_result($sformatf("vec%0d", i));
    end

    // Grant withheld for 4 cycles in the first ADD.
    run_op("7x3 stall", 32'd7, 32'd3, 32'd21, 1'b0, 9, 1, 4);
    take_result("7x3 stall");

    // Result back-pressure with new operands offered.
    run_op("5x6", 32'd5, 32'd6, 32'd30, 1'b0, 6, 0, 0);
    hold_res    = result;
    start_valid = 1'b1;
    op_a        = 32'd99;
    op_b        = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d result_valid", i), W'(result_valid), W'(1));
      check($sformatf("hold%0d result", i),       result,           hold_res);
      check($sformatf("hold%0d start_ready", i),  W'(start_ready),  W'(0));
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    start_valid  = 1'b0;
    check("post-hold start_ready", W'(start_ready),  W'(1));
    check("post-hold valid",       W'(result_valid), W'(0));
    check("post-hold acc kept",    result,           32'd30);

    // Reset in the middle of an operation (3 x 5, in the first SHL, acc=3).
    op_a = 32'd3;
    op_b = 32'd5;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-abort acc",      result,       32'd3);
    check("pre-abort ula_ctrl", W'(ula_ctrl), W'(3'b110));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post-abort%0d valid", i), W'(result_valid), W'(0));
      check($sformatf("post-abort%0d ready", i), W'(start_ready),  W'(1));
    end
    run_op("12x10 after reset", 32'd12, 32'd10, 32'd120, 1'b0, 7, 0, 0);
    take_result("12x10 after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
